uart_fifo_tx_param: RTL and testbench

Parametrised buffered UART transmitter: an inferred synchronous FIFO feeding a serialiser with configurable data width, FIFO depth, bit period, parity and stop bits. It replaces the fixed 8N1 FIFO+TX pair in the control/telemetry path and sits between any byte-producing logic and the board TX pin. Frames start automatically while `tx_en` is high and the FIFO holds data; a full FIFO drops the write and raises a sticky overflow flag.

---
 rtl/uart_fifo_tx_param.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_fifo_tx_param.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx_param.sv
// -----------------------------------------------------------------------------
// uart_fifo_tx_param
//   Buffered UART transmitter: a synchronous FIFO feeding a frame serialiser
//   with configurable payload width, FIFO depth, bit period, parity and stop
//   bit count. Frames start automatically from IDLE while tx_en is high and
//   the FIFO holds data. A write into a full FIFO is dropped and latches a
//   sticky overflow flag, unless a pop happens on the same edge.
//
// Ports
//   clk_in          in   1            sole clock
//   rst             in   1            synchronous, active-low reset
//   tx_en           in   1            permits starting new frames (IDLE only)
//   wr_en           in   1            write strobe
//   din             in   DATA_BITS    write data
//   full            out  1            occupancy == FIFO_DEPTH
//   almost_full     out  1            occupancy >= AF_LEVEL
//   empty           out  1            occupancy == 0
//   count           out  AW+1         FIFO occupancy
//   overflow        out  1            sticky, set by a dropped write
//   busy            out  1            serialiser not in IDLE
//   tx_done         out  1            pulse on the edge leaving the last stop bit
//   tx_serial_data  out  1            registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_fifo_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int AF_LEVEL     = FIFO_DEPTH - 2,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          tx_en,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          din,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          tx_serial_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
    localparam logic [PW-1:0] DEPTH_C    = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_C       = PW'(AF_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit for a payload word: even parity copies the XOR reduction,
    // odd parity inverts it so that data plus parity holds an odd number of ones.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY == 1) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [PW-1:0]        count_r;
    logic                 full_r;
    logic                 almost_full_r;
    logic                 empty_r;
    logic                 overflow_r;

    logic                 pop_s;
    logic                 wr_accept_s;
    logic [PW-1:0]        wr_ptr_nxt_s;
    logic [PW-1:0]        rd_ptr_nxt_s;
    logic [PW-1:0]        count_nxt_s;
    logic [DATA_BITS-1:0] head_s;

    // Serialiser state
    state_t               state_r;
    state_t               state_nxt_s;
    logic [TW-1:0]        timer_r;
    logic [TW-1:0]        timer_nxt_s;
    logic [BW-1:0]        bit_cnt_r;
    logic [BW-1:0]        bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic                 par_r;
    logic                 par_nxt_s;
    logic                 line_r;
    logic                 line_nxt_s;
    logic                 done_r;
    logic                 done_nxt_s;
    logic                 busy_r;

    // Pop/write decisions and next pointer values. A full FIFO still accepts
    // a write when the serialiser pops on the same edge, since a slot frees up.
    always_comb begin
        pop_s        = (state_r == S_IDLE) && tx_en && !empty_r;
        wr_accept_s  = wr_en && (!full_r || pop_s);
        wr_ptr_nxt_s = wr_accept_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        // The wrap bit makes the pointer difference span 0..FIFO_DEPTH.
        count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
        head_s       = mem_r[rd_ptr_r[AW-1:0]];
    end

    // FIFO data array; contents are discarded on reset via the pointers.
    always_ff @(posedge clk_in) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // FIFO pointers, occupancy and registered status flags.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            empty_r       <= 1'b1;
            overflow_r    <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            count_r       <= count_nxt_s;
            full_r        <= (count_nxt_s == DEPTH_C);
            almost_full_r <= (count_nxt_s >= AF_C);
            empty_r       <= (count_nxt_s == '0);
            overflow_r    <= overflow_r | (wr_en & full_r & ~pop_s);
        end
    end

    // Serialiser next-state logic and next registered line value.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        par_nxt_s     = par_r;
        done_nxt_s    = 1'b0;

        case (state_r)
            S_IDLE: begin
                timer_nxt_s   = '0;
                bit_cnt_nxt_s = '0;
                if (pop_s) begin
                    state_nxt_s = S_START;
                    shift_nxt_s = head_s;
                    par_nxt_s   = calc_parity(head_s);
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (timer_r == TIMER_LAST) begin
                    state_nxt_s   = S_DATA;
                    timer_nxt_s   = '0;
                    bit_cnt_nxt_s = '0;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_r == TIMER_LAST) begin
                    timer_nxt_s = '0;
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_nxt_s = '0;
                        if (PARITY != 0) begin
                            state_nxt_s = S_PARITY;
                        end else begin
                            state_nxt_s = S_STOP;
                        end
                    end else begin
                        // Next payload bit moves into position 0 on each bit boundary.
                        bit_cnt_nxt_s = bit_cnt_r + BW'(1);
                        shift_nxt_s   = shift_r >> 1'b1;
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            S_PARITY: begin
                if (timer_r == TIMER_LAST) begin
                    state_nxt_s   = S_STOP;
                    timer_nxt_s   = '0;
                    bit_cnt_nxt_s = '0;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            S_STOP: begin
                if (timer_r == TIMER_LAST) begin
                    timer_nxt_s = '0;
                    if (bit_cnt_r == STOP_LAST) begin
                        state_nxt_s   = S_IDLE;
                        bit_cnt_nxt_s = '0;
                        done_nxt_s    = 1'b1;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s   = S_IDLE;
                timer_nxt_s   = '0;
                bit_cnt_nxt_s = '0;
            end
        endcase

        // The line is registered from the state being entered so it changes
        // on the same edge as the state.
        case (state_nxt_s)
            S_START:  line_nxt_s = 1'b0;
            S_DATA:   line_nxt_s = shift_nxt_s[0];
            S_PARITY: line_nxt_s = par_nxt_s;
            default:  line_nxt_s = 1'b1;
        endcase
    end

    // Serialiser state register and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            timer_r   <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            par_r     <= 1'b0;
            line_r    <= 1'b1;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            par_r     <= par_nxt_s;
            line_r    <= line_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= (state_nxt_s != S_IDLE);
        end
    end

    assign full           = full_r;
    assign almost_full    = almost_full_r;
    assign empty          = empty_r;
    assign count          = count_r;
    assign overflow       = overflow_r;
    assign busy           = busy_r;
    assign tx_done        = done_r;
    assign tx_serial_data = line_r;

endmodule

// File: tb/tb_uart_fifo_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_tx_param
//   Scoreboard bench for uart_fifo_tx_param. Instance A: 8 data bits, even
//   parity, 1 stop bit, 4-deep FIFO (AF_LEVEL 2), 4 clocks per bit. Instance B:
//   8 data bits, odd parity, 2 stop bits, 16-deep FIFO, 4 clocks per bit.
//   Stimulus pushes {parity, data} words (parity hand-computed) into per-
//   instance queues; line monitors pop them at each start bit and compare
//   every bit slot, the tx_done pulse and the frame length.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_fifo_tx_param;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic       wr_en;
    logic [7:0] din;
    logic       tx_en_b;
    logic       wr_b;
    logic [7:0] din_b;

    logic       full_a, af_a, empty_a, ovf_a, busy_a, done_a, line_a;
    logic [2:0] count_a;
    logic       full_b, af_b, empty_b, ovf_b, busy_b, done_b, line_b;
    logic [4:0] count_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt_a  = 0;

    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    int         start_q_a[$];
    int         cnt_q_a[$];
    int         start_q_b[$];
    bit         mon_a_act = 1'b0;
    bit         mon_b_act = 1'b0;

    uart_fifo_tx_param #(
        .DATA_BITS(8), .FIFO_DEPTH(4), .AF_LEVEL(2),
        .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)
    ) dut_a (
        .clk_in(clk), .rst(rst), .tx_en(tx_en), .wr_en(wr_en), .din(din),
        .full(full_a), .almost_full(af_a), .empty(empty_a), .count(count_a),
        .overflow(ovf_a), .busy(busy_a), .tx_done(done_a), .tx_serial_data(line_a)
    );

    uart_fifo_tx_param #(
        .DATA_BITS(8), .FIFO_DEPTH(16),
        .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)
    ) dut_b (
        .clk_in(clk), .rst(rst), .tx_en(tx_en_b), .wr_en(wr_b), .din(din_b),
        .full(full_b), .almost_full(af_b), .empty(empty_b), .count(count_b),
        .overflow(ovf_b), .busy(busy_b), .tx_done(done_b), .tx_serial_data(line_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic line_of(input bit inst);
        return inst ? line_b : line_a;
    endfunction

    function automatic logic done_of(input bit inst);
        return inst ? done_b : done_a;
    endfunction

    // Called at the negedge where the start bit is first seen.
    task automatic check_frame(input bit inst, input logic [8:0] ent, input int nstop);
        logic bits [0:12];
        int   nslots;
        bit   bad;
        bit   aborted;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = ent[i];
        bits[9] = ent[8];
        for (int k = 0; k < 3; k++) bits[10+k] = 1'b1;
        nslots  = 10 + nstop;
        aborted = 1'b0;
        for (int s = 0; s < nslots; s++) begin
            bad = 1'b0;
            for (int c = 0; c < CPB; c++) begin
                if (s > 0 || c > 0) @(negedge clk);
                if (!rst) begin
                    aborted = 1'b1;
                    break;
                end else if (line_of(inst) !== bits[s] || done_of(inst) !== 1'b0) begin
                    bad = 1'b1;
                end
            end
            if (aborted) break;
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL slot%0d inst%0d word %0h: line/tx_done not %0b/0 for whole slot",
                         s, inst, ent, bits[s]);
            end
        end
        if (!aborted) begin
            @(negedge clk);
            chk(inst ? "done_b_pulse" : "done_a_pulse",
                {30'd0, done_of(inst), line_of(inst)}, 32'd3);
        end
    endtask

    // Monitor A: pops the expected word at each start bit.
    initial begin : mon_a
        logic       prev;
        logic [8:0] ent;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && prev === 1'b1 && line_a === 1'b0) begin
                mon_a_act = 1'b1;
                start_q_a.push_back(cyc);
                cnt_q_a.push_back(int'(count_a));
                if (exp_a.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame_a: frame started with queue empty at cycle %0d", cyc);
                    ent = 9'h1FF;
                end else begin
                    ent = exp_a.pop_front();
                end
                check_frame(1'b0, ent, 1);
                mon_a_act = 1'b0;
            end
            prev = line_a;
        end
    end

    // Monitor B: two stop bits, odd parity.
    initial begin : mon_b
        logic       prev;
        logic [8:0] ent;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && prev === 1'b1 && line_b === 1'b0) begin
                mon_b_act = 1'b1;
                start_q_b.push_back(cyc);
                if (exp_b.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame_b: frame started with queue empty at cycle %0d", cyc);
                    ent = 9'h1FF;
                end else begin
                    ent = exp_b.pop_front();
                end
                check_frame(1'b1, ent, 2);
                mon_b_act = 1'b0;
            end
            prev = line_b;
        end
    end

    task automatic write_word(input logic [7:0] d);
        wr_en = 1'b1;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            ok = (exp_a.size() == 0) && (exp_b.size() == 0) && !busy_a && !busy_b
                 && !mon_a_act && !mon_b_act;
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        int t_cnt  [5];
        int t_af   [5];
        int t_full [5];
        int t_ovf  [5];
        int base;
        t_cnt  = '{1, 2, 3, 4, 4};
        t_af   = '{0, 1, 1, 1, 1};
        t_full = '{0, 0, 0, 1, 1};
        t_ovf  = '{0, 0, 0, 0, 1};

        rst = 1'b0; tx_en = 1'b1; wr_en = 1'b1; din = 8'h55;
        tx_en_b = 1'b1; wr_b = 1'b0; din_b = 8'h00;

        // Reset held 3 cycles with a write strobe active.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_empty",    {31'd0, empty_a}, 32'd1);
        chk("rst_full",     {31'd0, full_a},  32'd0);
        chk("rst_af",       {31'd0, af_a},    32'd0);
        chk("rst_ovf",      {31'd0, ovf_a},   32'd0);
        chk("rst_busy",     {31'd0, busy_a},  32'd0);
        chk("rst_done",     {31'd0, done_a},  32'd0);
        chk("rst_line",     {31'd0, line_a},  32'd1);
        chk("rst_count",    {29'd0, count_a}, 32'd0);
        chk("rst_line_b",   {31'd0, line_b},  32'd1);
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_count", {29'd0, count_a}, 32'd0);
        chk("post_rst_busy",  {31'd0, busy_a},  32'd0);
        chk("post_rst_line",  {31'd0, line_a},  32'd1);

        // Single 0xA5 frame: even parity 0 on A, odd parity 1 on B.
        exp_a.push_back({1'b0, 8'hA5});
        exp_b.push_back({1'b1, 8'hA5});
        wr_b = 1'b1; din_b = 8'hA5;
        write_word(8'hA5);
        wr_b = 1'b0;
        w = cyc;
        @(negedge clk);
        chk("a5_count_after_write", {29'd0, count_a}, 32'd1);
        chk("a5_empty_after_write", {31'd0, empty_a}, 32'd0);
        @(negedge clk);
        chk("a5_count_after_pop", {29'd0, count_a}, 32'd0);
        chk("a5_busy",            {31'd0, busy_a},  32'd1);
        wait_idle(200, "a5_complete");
        chk("a5_starts_a", start_q_a.size(), 32'd1);
        if (start_q_a.size() > 0) chk("a5_latency_a", start_q_a[0], w + 1);
        chk("a5_starts_b", start_q_b.size(), 32'd1);
        if (start_q_b.size() > 0) chk("a5_latency_b", start_q_b[0], w + 1);
        start_q_a.delete(); cnt_q_a.delete(); start_q_b.delete();

        // Burst of three with transmit held off, then released.
        tx_en = 1'b0;
        exp_a.push_back({1'b1, 8'h01});
        exp_a.push_back({1'b1, 8'h02});
        exp_a.push_back({1'b0, 8'h03});
        write_word(8'h01);
        write_word(8'h02);
        write_word(8'h03);
        @(negedge clk);
        chk("burst_count", {29'd0, count_a}, 32'd3);
        chk("burst_af",    {31'd0, af_a},    32'd1);
        chk("burst_full",  {31'd0, full_a},  32'd0);
        @(posedge clk); #1;
        base  = done_cnt_a;
        tx_en = 1'b1;
        wait_idle(600, "burst_complete");
        @(posedge clk); #1;
        chk("burst_done_pulses", done_cnt_a - base, 32'd3);
        chk("burst_starts", start_q_a.size(), 32'd3);
        if (start_q_a.size() == 3) begin
            chk("burst_count_pop1", cnt_q_a[0], 32'd2);
            chk("burst_count_pop2", cnt_q_a[1], 32'd1);
            chk("burst_count_pop3", cnt_q_a[2], 32'd0);
            chk("burst_gap1", start_q_a[1] - start_q_a[0], 32'd45);
            chk("burst_gap2", start_q_a[2] - start_q_a[1], 32'd45);
        end
        start_q_a.delete(); cnt_q_a.delete();

        // Fill past full with transmit held off; fifth write dropped.
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            write_word(8'h10 + 8'(i));
            @(negedge clk);
            chk("fill_count", {29'd0, count_a}, t_cnt[i]);
            chk("fill_af",    {31'd0, af_a},    t_af[i]);
            chk("fill_full",  {31'd0, full_a},  t_full[i]);
            chk("fill_ovf",   {31'd0, ovf_a},   t_ovf[i]);
        end
        exp_a.push_back({1'b1, 8'h10});
        exp_a.push_back({1'b0, 8'h11});
        exp_a.push_back({1'b0, 8'h12});
        exp_a.push_back({1'b1, 8'h13});
        @(posedge clk); #1;
        tx_en = 1'b1;
        wait_idle(1000, "drain_complete");
        chk("drain_starts", start_q_a.size(), 32'd4);
        chk("drain_ovf_sticky", {31'd0, ovf_a}, 32'd1);
        chk("drain_empty",      {31'd0, empty_a}, 32'd1);
        start_q_a.delete(); cnt_q_a.delete();

        // Reset clears overflow; then write and pop on the same edge while full.
        @(posedge clk); #1;
        tx_en = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ovf_cleared", {31'd0, ovf_a}, 32'd0);
        exp_a.push_back({1'b1, 8'h20});
        exp_a.push_back({1'b0, 8'h21});
        exp_a.push_back({1'b0, 8'h22});
        exp_a.push_back({1'b1, 8'h23});
        write_word(8'h20);
        write_word(8'h21);
        write_word(8'h22);
        write_word(8'h23);
        @(negedge clk);
        chk("sim_full_before", {31'd0, full_a}, 32'd1);
        @(posedge clk); #1;
        tx_en = 1'b1; wr_en = 1'b1; din = 8'h15;
        exp_a.push_back({1'b1, 8'h15});
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("sim_count", {29'd0, count_a}, 32'd4);
        chk("sim_ovf",   {31'd0, ovf_a},   32'd0);
        chk("sim_busy",  {31'd0, busy_a},  32'd1);
        wait_idle(1500, "sim_complete");
        chk("sim_starts", start_q_a.size(), 32'd5);
        start_q_a.delete(); cnt_q_a.delete();

        // Drop tx_en mid-frame: current frame completes, second word stays queued.
        exp_a.push_back({1'b0, 8'h3C});
        write_word(8'h3C);
        write_word(8'h7E);
        repeat (10) @(posedge clk);
        #1;
        tx_en = 1'b0;
        wait_idle(200, "gate_complete");
        repeat (20) @(negedge clk);
        chk("gate_busy",   {31'd0, busy_a},  32'd0);
        chk("gate_count",  {29'd0, count_a}, 32'd1);
        chk("gate_line",   {31'd0, line_a},  32'd1);
        chk("gate_starts", start_q_a.size(), 32'd1);

        // Release the queued word and reset while it is in its data bits.
        exp_a.push_back({1'b0, 8'h7E});
        @(posedge clk); #1;
        tx_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_line",  {31'd0, line_a},  32'd1);
        chk("abort_busy",  {31'd0, busy_a},  32'd0);
        chk("abort_count", {29'd0, count_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy_a}, 32'd0);
        chk("exp_a_drained", exp_a.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
